// File: rtl/gray_step_monitor_if.sv
// -----------------------------------------------------------------------------
// gray_step_monitor_if
//
// Purpose : Bundles the Gray bus input, the error-clear control and all of the
//           monitor's status outputs, so that a Gray source/controller and the
//           monitor connect through one port.
//
// Parameters:
//   WIDTH  width of the Gray bus and of the binary output
//   POS_W  width of the signed position accumulator
//
// Signals:
//   gray_in     Gray code from the upstream counter (source -> monitor)
//   clr_err     synchronous clear of fault state / sticky error (source -> monitor)
//   bin_out     registered binary equivalent of the last sampled gray_in
//   valid       a reference sample exists (monitor tracking or faulted)
//   step_up     one-cycle pulse on a legal +1 step
//   step_dn     one-cycle pulse on a legal -1 step
//   dir_out     last legal step direction, 1 = up
//   pos         signed net step count
//   err         one-cycle pulse on the first illegal transition
//   err_sticky  latched error
//   err_cnt     illegal-transition counter (only with GRAY_MON_ERRCNT_EN)
//
// Modports:
//   master  the side that drives gray_in/clr_err and observes the status
//   slave   the monitor itself
//
// Build option: define GRAY_MON_ERRCNT_EN to add err_cnt.
// -----------------------------------------------------------------------------
interface gray_step_monitor_if #(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
);
    logic [WIDTH-1:0]        gray_in;
    logic                    clr_err;
    logic [WIDTH-1:0]        bin_out;
    logic                    valid;
    logic                    step_up;
    logic                    step_dn;
    logic                    dir_out;
    logic signed [POS_W-1:0] pos;
    logic                    err;
    logic                    err_sticky;
`ifdef GRAY_MON_ERRCNT_EN
    logic [7:0]              err_cnt;
`endif

    modport master (
`ifdef GRAY_MON_ERRCNT_EN
        input  err_cnt,
`endif
        output gray_in, clr_err,
        input  bin_out, valid, step_up, step_dn, dir_out, pos, err, err_sticky
    );

    modport slave (
`ifdef GRAY_MON_ERRCNT_EN
        output err_cnt,
`endif
        input  gray_in, clr_err,
        output bin_out, valid, step_up, step_dn, dir_out, pos, err, err_sticky
    );
endinterface

// File: rtl/gray_step_monitor.sv
// -----------------------------------------------------------------------------
// gray_step_monitor
//
// Purpose : Samples a Gray-coded counter bus every clock, converts it to
//           binary, classifies each sample-to-sample change as hold / up /
//           down / illegal, keeps a signed position accumulator and reports
//           Gray-sequence violations (pulse + sticky flag).
//
// Ports:
//   clk  rising-edge clock, same domain as the Gray source
//   rst  asynchronous, active-high reset
//   mon  gray_step_monitor_if.slave
//          in : gray_in, clr_err
//          out: bin_out, valid, step_up, step_dn, dir_out, pos, err,
//               err_sticky (+ err_cnt with GRAY_MON_ERRCNT_EN)
//
// Operating modes:
//   IDLE   capture a reference sample only, then go to TRACK
//   TRACK  classify every change; an illegal change enters FAULT
//   FAULT  position and direction frozen until clr_err re-arms via IDLE
//
// Build option: GRAY_MON_ERRCNT_EN adds an 8-bit saturating count of illegal
// transitions seen in TRACK and FAULT (cleared by clr_err in any state).
// Without it, only the first violation is reported (the err pulse on entry
// to FAULT).
// -----------------------------------------------------------------------------
module gray_step_monitor #(
    parameter int WIDTH = 4,
    parameter int POS_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    gray_step_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t                  state_q,   state_d;
    // bin_q is both the registered binary output and the reference sample for
    // the next classification; a separate "prev" copy would always be equal.
    logic [WIDTH-1:0]        bin_q,     bin_d;
    logic                    step_up_q, step_up_d;
    logic                    step_dn_q, step_dn_d;
    logic                    dir_q,     dir_d;
    logic signed [POS_W-1:0] pos_q,     pos_d;
    logic                    err_q,     err_d;
    logic                    sticky_q,  sticky_d;

    // -------------------------------------------------------------------------
    // Gray -> binary: b[i] is the XOR of all Gray bits at or above i, i.e. the
    // XOR of the Gray word shifted right by 0..WIDTH-1.
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        for (int s = 0; s < WIDTH; s++) begin
            b = b ^ (g >> s);
        end
        return b;
    endfunction

    logic [WIDTH-1:0] b_now;
    logic [WIDTH-1:0] diff;
    logic             is_up;
    logic             is_dn;
    logic             is_ill;

    // The modulo-2^WIDTH difference makes the wrap cases (max -> 0 and
    // 0 -> max) fall out as ordinary +1 / -1 steps. Classification is on the
    // binary distance, so a one-bit Gray change that skips codes is illegal.
    always_comb begin
        b_now  = gray2bin(mon.gray_in);
        diff   = b_now - bin_q;
        is_up  = (diff == WIDTH'(1));
        is_dn  = (diff == '1);
        is_ill = (diff != '0) && !is_up && !is_dn;
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; that is what keeps this block free of inferred latches.
        state_d   = state_q;
        bin_d     = b_now;
        step_up_d = 1'b0;
        step_dn_d = 1'b0;
        dir_d     = dir_q;
        pos_d     = pos_q;
        err_d     = 1'b0;
        sticky_d  = sticky_q;

        unique case (state_q)
            IDLE: begin
                // Reference capture only; clr_err has nothing to clear here.
                state_d = TRACK;
            end

            TRACK: begin
                if (mon.clr_err) begin
                    sticky_d = 1'b0;
                end
                if (is_up) begin
                    step_up_d = 1'b1;
                    pos_d     = pos_q + POS_W'(1);
                    dir_d     = 1'b1;
                end else if (is_dn) begin
                    step_dn_d = 1'b1;
                    pos_d     = pos_q - POS_W'(1);
                    dir_d     = 1'b0;
                end else if (is_ill) begin
                    // A fresh violation outranks a simultaneous clear.
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = FAULT;
                end
            end

            FAULT: begin
                // Frozen; only a clear (which beats any concurrent violation)
                // leaves this state, restarting the position from zero.
                if (mon.clr_err) begin
                    sticky_d = 1'b0;
                    pos_d    = '0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            dir_q     <= 1'b1;
            pos_q     <= '0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            bin_q     <= bin_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            dir_q     <= dir_d;
            pos_q     <= pos_d;
            err_q     <= err_d;
            sticky_q  <= sticky_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional illegal-transition counter
    // -------------------------------------------------------------------------
`ifdef GRAY_MON_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts every violation while a reference exists, including the ones
    // that FAULT otherwise swallows silently; holds at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mon.clr_err) begin
            err_cnt_d = '0;
        end else if ((state_q != IDLE) && is_ill && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign mon.err_cnt = err_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mon.bin_out    = bin_q;
    assign mon.valid      = (state_q != IDLE);
    assign mon.step_up    = step_up_q;
    assign mon.step_dn    = step_dn_q;
    assign mon.dir_out    = dir_q;
    assign mon.pos        = pos_q;
    assign mon.err        = err_q;
    assign mon.err_sticky = sticky_q;

    // At most one of the event pulses may be active in any cycle.
    pulse_exclusive_a: assert property (
        @(posedge clk) disable iff (rst) $onehot0({step_up_q, step_dn_q, err_q})
    );

endmodule

// File: tb/tb_gray_step_monitor.sv
// -----------------------------------------------------------------------------
// tb_gray_step_monitor
//
// Self-checking bench for gray_step_monitor. A behavioural model (integer
// position, table-search Gray decode, modular distance) predicts every output
// after each clock edge. Directed sequences cover the listed scenarios, then a
// random walk mixes holds, steps, jumps and clears. POS_W is reduced so the
// accumulator wrap is reachable quickly.
// Define GRAY_MON_ERRCNT_EN for both RTL and bench to cover err_cnt.
// -----------------------------------------------------------------------------
module tb_gray_step_monitor;

    localparam int W    = 4;
    localparam int PW   = 8;
    localparam int NCOD = 1 << W;

    logic clk;
    logic rst;

    gray_step_monitor_if #(.WIDTH(W), .POS_W(PW)) mon_if ();

    gray_step_monitor #(.WIDTH(W), .POS_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    int m_mode;   // 0 = waiting for reference, 1 = tracking, 2 = faulted
    int m_prev;
    int m_pos;
    int m_dir;
    int m_up, m_dn, m_err, m_sticky, m_cnt;

    function automatic logic [W-1:0] to_gray(input int b);
        return W'(b ^ (b >> 1));
    endfunction

    // Decode by finding the code whose Gray image matches.
    function automatic int from_gray(input logic [W-1:0] g);
        for (int b = 0; b < NCOD; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_prev = 0; m_pos = 0; m_dir = 1;
        m_up = 0; m_dn = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] g, input logic clr);
        int b, d, old_mode;
        b = from_gray(g);
        d = (b - m_prev + NCOD) % NCOD;
        old_mode = m_mode;
        m_up = 0; m_dn = 0; m_err = 0;
        if (old_mode == 0) begin
            m_mode = 1;
        end else if (old_mode == 1) begin
            if (clr) m_sticky = 0;
            if (d == 1) begin
                m_up = 1; m_dir = 1;
                m_pos = m_pos + 1;
                if (m_pos > (1 << (PW - 1)) - 1) m_pos -= (1 << PW);
            end else if (d == NCOD - 1) begin
                m_dn = 1; m_dir = 0;
                m_pos = m_pos - 1;
                if (m_pos < -(1 << (PW - 1))) m_pos += (1 << PW);
            end else if (d != 0) begin
                m_err = 1; m_sticky = 1; m_mode = 2;
            end
        end else begin
            if (clr) begin
                m_sticky = 0; m_pos = 0; m_mode = 0;
            end
        end
        if (clr) m_cnt = 0;
        else if (old_mode != 0 && d != 0 && d != 1 && d != NCOD - 1 && m_cnt < 255)
            m_cnt++;
        m_prev = b;
    endtask

    task automatic compare_all(input string where);
        check({where, ".bin_out"},    32'(mon_if.bin_out),    32'(m_prev));
        check({where, ".valid"},      32'(mon_if.valid),      32'(m_mode != 0));
        check({where, ".step_up"},    32'(mon_if.step_up),    32'(m_up));
        check({where, ".step_dn"},    32'(mon_if.step_dn),    32'(m_dn));
        check({where, ".dir_out"},    32'(mon_if.dir_out),    32'(m_dir));
        check({where, ".pos"},        32'(mon_if.pos),        32'(m_pos));
        check({where, ".err"},        32'(mon_if.err),        32'(m_err));
        check({where, ".err_sticky"}, 32'(mon_if.err_sticky), 32'(m_sticky));
`ifdef GRAY_MON_ERRCNT_EN
        check({where, ".err_cnt"},    32'(mon_if.err_cnt),    32'(m_cnt));
`endif
    endtask

    // Drive inputs mid-cycle, update the model on the edge, check 1 ns later.
    task automatic drive(input string where, input logic [W-1:0] g, input logic clr);
        @(negedge clk);
        mon_if.gray_in = g;
        mon_if.clr_err = clr;
        @(posedge clk);
        model_edge(g, clr);
        #1;
        compare_all(where);
    endtask

    task automatic step_bin(input string where, input int b);
        drive(where, to_gray(b), 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mon_if.gray_in = '0;
        mon_if.clr_err = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        #9;
        rst = 1'b0;
    endtask

    int cur;
    int err_pulses;

    initial begin
        rst = 1'b1;
        mon_if.gray_in = '0;
        mon_if.clr_err = 1'b0;
        model_reset();
        #3;
        compare_all("por");
        #7;
        rst = 1'b0;

        // Reset then count up through Gray 0000,0001,0011,0010,0110.
        drive("up0", 4'b0000, 1'b0);
        drive("up1", 4'b0001, 1'b0);
        drive("up2", 4'b0011, 1'b0);
        drive("up3", 4'b0010, 1'b0);
        drive("up4", 4'b0110, 1'b0);
        check("up.pos_is_4", 32'(mon_if.pos), 32'd4);
        check("up.bin_is_4", 32'(mon_if.bin_out), 32'd4);

        // Walk up to 15, then wrap to 0.
        for (int b = 5; b < NCOD; b++) step_bin("walk", b);
        drive("upwrap", 4'b0000, 1'b0);
        check("upwrap.step_up", 32'(mon_if.step_up), 32'd1);

        // Count down from 3 through the 0 -> 15 wrap.
        for (int b = 1; b <= 3; b++) step_bin("walk", b);
        drive("dn1", 4'b0011, 1'b0);
        drive("dn2", 4'b0001, 1'b0);
        drive("dn3", 4'b0000, 1'b0);
        drive("dn4", 4'b1000, 1'b0);
        check("dn.bin_is_15", 32'(mon_if.bin_out), 32'd15);
        check("dn.dir", 32'(mon_if.dir_out), 32'd0);

        // One-bit Gray change that skips codes (0 -> 3) is illegal.
        step_bin("walk", 0);
        drive("ill", 4'b0010, 1'b0);
        check("ill.err", 32'(mon_if.err), 32'd1);
        step_bin("frz", 2);
        step_bin("frz", 1);
        step_bin("frz_jump", 9);
        drive("clr", to_gray(9), 1'b1);
        check("clr.valid_low", 32'(mon_if.valid), 32'd0);
        step_bin("ref", 12);
        step_bin("after_ref", 13);

        // Clear in FAULT coinciding with an illegal jump: clear wins.
        step_bin("ill2", 2);
        drive("clr_vs_ill", to_gray(7), 1'b1);
        step_bin("ref2", 7);

        // Async reset between edges with pos=5 and sticky set.
        do_reset();
        step_bin("ar_ref", 0);
        for (int b = 1; b <= 5; b++) step_bin("ar_up", b);
        step_bin("ar_ill", 11);
        check("ar.pos_is_5", 32'(mon_if.pos), 32'd5);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step_bin("ar_recap", 11);
        step_bin("ar_step", 12);

        // Accumulator wrap: +127 + 1 -> -128.
        cur = 12;
        for (int i = 0; i < (1 << PW) + 4; i++) begin
            cur = (cur + 1) % NCOD;
            step_bin("poswrap", cur);
        end

`ifdef GRAY_MON_ERRCNT_EN
        do_reset();
        step_bin("ec_ref", 0);
        err_pulses = 0;
        step_bin("ec1", 5);  err_pulses += int'(mon_if.err);
        step_bin("ec2", 9);  err_pulses += int'(mon_if.err);
        step_bin("ec3", 2);  err_pulses += int'(mon_if.err);
        check("ec.count3", 32'(mon_if.err_cnt), 32'd3);
        check("ec.one_pulse", 32'(err_pulses), 32'd1);
        drive("ec_clr", to_gray(2), 1'b1);
        check("ec.cleared", 32'(mon_if.err_cnt), 32'd0);
        for (int i = 0; i < 262; i++) step_bin("ec_sat", (i % 2 == 0) ? 8 : 0);
        check("ec.sat", 32'(mon_if.err_cnt), 32'd255);
        drive("ec_clr2", to_gray(0), 1'b1);
`endif

        // Random walk.
        do_reset();
        cur = $urandom_range(0, NCOD - 1);
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic c;
            r = $urandom_range(0, 99);
            c = 1'b0;
            if (r < 25) begin
                // hold
            end else if (r < 55) begin
                cur = (cur + 1) % NCOD;
            end else if (r < 85) begin
                cur = (cur + NCOD - 1) % NCOD;
            end else if (r < 94) begin
                cur = $urandom_range(0, NCOD - 1);
            end else begin
                c = 1'b1;
                if ($urandom_range(0, 1) == 1) cur = $urandom_range(0, NCOD - 1);
            end
            drive("rand", to_gray(cur), c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
